// File: rtl/esm_issue_scheduler.sv
// esm_issue_scheduler: slot occupancy map, core select handshake, issue FSM.
// Define ESM_SCHED_TIMEOUT_EN to enable the issue-handshake watchdog.
module esm_issue_scheduler #(
    parameter int bs       = 16,
    parameter int core_lat = 2,
    parameter int timeout  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [$clog2(bs)-1:0] alloc_index,
    input  logic [0:bs-1]         operand_ready,
    output logic [0:bs-1]         independent_instr,
    input  logic [$clog2(bs)-1:0] core_index,
    input  logic                  core_valid,
    output logic                  issue_valid,
    output logic [$clog2(bs)-1:0] issue_index,
    input  logic                  issue_ready,
    output logic [$clog2(bs):0]   occupancy,
    output logic                  timeout_err
);

    localparam int iw = $clog2(bs);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE
    } state_t;

    state_t        state;
    logic [0:bs-1] occupied;
    logic [0:bs-1] occ_next;
    logic [0:bs-1] elig;
    logic [3:0]    wait_cnt;
    logic          alloc_fire;
    logic          issue_fire;
    logic          sel_ok;
    logic          any_free;
    logic [iw-1:0] free_idx;
    logic [iw:0]   occ_cnt_next;
    logic          to_expire;

    assign elig       = occupied & operand_ready;
    assign alloc_fire = alloc_valid & alloc_ready;
    assign issue_fire = (state == ISSUE) & issue_ready;
    assign sel_ok     = core_valid & independent_instr[core_index];

    // The issuing slot is occupied, so it can never be the alloc target.
    always_comb begin
        occ_next = occupied;
        if (alloc_fire) occ_next[alloc_index] = 1'b1;
        if (issue_fire) occ_next[issue_index] = 1'b0;
    end

    assign occ_cnt_next = occupancy
                        + (iw+1)'(alloc_fire)
                        - (iw+1)'(issue_fire);

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!occ_next[i]) begin
                any_free = 1'b1;
                free_idx = iw'(i);
            end
        end
    end

`ifdef ESM_SCHED_TIMEOUT_EN
    localparam int tw = $clog2(timeout + 1);

    logic [tw-1:0] to_cnt;

    assign to_expire = (state == ISSUE) & !issue_ready
                     & (to_cnt == tw'(timeout - 1));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_expire;
            if (state != ISSUE || to_expire)
                to_cnt <= '0;
            else if (!issue_ready)
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state             <= IDLE;
            occupied          <= '0;
            occupancy         <= '0;
            alloc_ready       <= 1'b1;
            alloc_index       <= '0;
            independent_instr <= '0;
            issue_valid       <= 1'b0;
            issue_index       <= '0;
            wait_cnt          <= '0;
        end else begin
            occupied    <= occ_next;
            occupancy   <= occ_cnt_next;
            alloc_ready <= any_free;
            alloc_index <= free_idx;
            unique case (state)
                IDLE: begin
                    if (|elig) begin
                        independent_instr <= elig;
                        wait_cnt          <= 4'(core_lat);
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        independent_instr <= '0;
                        if (sel_ok) begin
                            issue_index <= core_index;
                            issue_valid <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ISSUE: begin
                    // A watchdog expiry leaves the slot occupied for reselection.
                    if (issue_ready || to_expire) begin
                        issue_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/esm_issue_scheduler.md
# esm_issue_scheduler

Issue controller wrapped around the ESM core. It holds a `bs`-entry instruction-slot occupancy map and accepts allocations into free slots. It presents the set of issue-eligible slots (occupied, operands ready) to the core as `independent_instr` and waits out the core's fixed response latency. It then issues the core-selected slot to the execution stage over a valid/ready handshake and frees that slot on acceptance.

## Interface
- `bs`, 16: number of instruction slots; power of two, ≥ 2.
- `core_lat`, 2: cycles from a mask being driven on `independent_instr` until `core_index`/`core_valid` correspond to it; 1–15.
- `timeout`, 64: issue-handshake watchdog limit in cycles; used only with `ESM_SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  clears all slots and aborts any selection in progress.
- `alloc_valid`  in  1  request to occupy a slot.
- `alloc_ready`  out  1  at least one slot is free.
- `alloc_index`  out  $clog2(bs)  lowest-numbered free slot; meaningful only while `alloc_ready` = 1.
- `operand_ready`  in  [0:bs-1]  bit i = 1 when slot i's operands are available.
- `independent_instr`  out  [0:bs-1]  eligible mask driven to the core.
- `core_index`  in  $clog2(bs)  slot chosen by the core.
- `core_valid`  in  1  the core's selection is valid (`valid_count`).
- `issue_valid`  out  1  issue request.
- `issue_index`  out  $clog2(bs)  slot being issued.
- `issue_ready`  in  1  the execution stage accepts the issue.
- `occupancy`  out  $clog2(bs)+1  number of occupied slots.
- `timeout_err`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Eligibility: `elig = occupied & operand_ready`.
- Allocation: a handshake completes when `alloc_valid & alloc_ready`. It sets `occupied[alloc_index]`. Only one allocation is accepted per cycle.
- The slot being issued is occupied, so it is never the allocation target in the same cycle. A slot freed by an issue becomes allocatable the next cycle.
- States:
  - IDLE. `independent_instr` = 0. If `elig` ≠ 0, register `elig` into `independent_instr`, load `wait_cnt = core_lat`, and go to WAIT. Otherwise stay in IDLE.
  - WAIT. Hold `independent_instr` constant and decrement `wait_cnt`. Changes on `operand_ready` are ignored.
  - WAIT exit, on the cycle `wait_cnt` = 1: sample `core_valid`/`core_index`.
    - If `core_valid` = 1 and `independent_instr[core_index]` = 1, latch the index into `issue_index` and go to ISSUE.
    - Otherwise go to IDLE and issue nothing.
    - In both cases `independent_instr` is zeroed.
  - ISSUE. `issue_valid` = 1 and `issue_index` is stable. On `issue_ready` = 1: clear `occupied[issue_index]` and go to IDLE.
- `occupancy` adds 1 for an accepted allocation and subtracts 1 for an accepted issue; both in the same cycle leave it unchanged. It never exceeds `bs`.
- Full: `alloc_ready` = 0 and `alloc_valid` is ignored.
- Empty: the block stays in IDLE.
- `flush` has priority over all activity except `rst`. It clears `occupied`, returns to IDLE, zeroes all outputs, and drops any same-cycle allocation or issue acceptance.

## Timing
- Values after `rst`, or the cycle after `flush`:
  - state IDLE;
  - `occupied` = 0, `occupancy` = 0;
  - `alloc_ready` = 1, `alloc_index` = 0;
  - `independent_instr` = 0;
  - `issue_valid` = 0, `issue_index` = 0;
  - `timeout_err` = 0.
- Reset in the middle of WAIT or ISSUE discards the selection. No issue handshake completes in the reset cycle.
- Allocation is accepted at edge E, making the slot occupied from E. If its operands are ready, `independent_instr` is driven from E+1. `issue_valid` rises at E+1+`core_lat`.
- Back-to-back throughput: at most one issue per `core_lat`+2 cycles when `issue_ready` is held high (1 IDLE + `core_lat` WAIT + 1 ISSUE).
- `alloc_ready`, `alloc_index` and `occupancy` are registered, updated on the edge that changes `occupied`.
- `issue_valid` never drops without acceptance, except on `rst`, `flush`, or a watchdog expiry.

## Configuration
- Macro `ESM_SCHED_TIMEOUT_EN`.
- When defined:
  - A counter runs while in ISSUE.
  - If `issue_ready` has stayed low for `timeout` cycles, the block drops `issue_valid`, keeps the slot occupied and returns to IDLE, so the slot is eligible for reselection.
  - `timeout_err` pulses high for one cycle on that edge.
- When undefined: no counter, `timeout_err` is tied to 0, and ISSUE waits indefinitely.

## Test plan
- Reset → every output at its reset value; `alloc_ready` = 1, `alloc_index` = 0, `occupancy` = 0.
- Single path, `core_lat` = 2:
  - Stimulus: allocate slot 0 with `operand_ready` = all ones; core model returns index 0 with valid after 2 cycles; `issue_ready` held high.
  - Required response: `independent_instr` = 0x8000 (bit 0 in [0:15] ordering) one cycle after acceptance; `issue_valid` with `issue_index` = 0 three cycles after acceptance.
  - Required response: `occupancy` back to 0 after the issue.
- Fill and full:
  - Stimulus: 16 allocations with `operand_ready` = 0.
  - Required response: `alloc_index` runs 0..15, then `alloc_ready` = 0 and `occupancy` = 16.
  - Stimulus: issue slot 5.
  - Required response: next cycle `alloc_ready` = 1 with `alloc_index` = 5.
- Invalid core response:
  - Case A: `core_valid` = 0 → `issue_valid` stays 0, FSM returns to IDLE, slot remains occupied.
  - Case B: `core_index` names a slot outside the mask → same result as case A.
- Assert `flush` while in WAIT with 3 slots occupied → next cycle `occupancy` = 0, `independent_instr` = 0, and no issue follows.
- `ESM_SCHED_TIMEOUT_EN` with `timeout` = 64 and `issue_ready` held low → `issue_valid` drops after 64 cycles and `timeout_err` pulses once. The slot is then reselected and issued once `issue_ready` = 1.
